uart_cmd_sequencer: RTL

//  Command sequencer between the UART receiver byte stream and the multiplier core.

---
 rtl/uart_cmd_pkg.sv | 29 ++
 rtl/uart_cmd_timeout.sv | 39 +++
 rtl/uart_cmd_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command sequencer.
// States are plain localparams so older tools and dumps show raw codes.
package uart_cmd_pkg;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_CMD  = 4'd1;
  localparam logic [3:0] S_OPA  = 4'd2;
  localparam logic [3:0] S_OPB  = 4'd3;
  localparam logic [3:0] S_CHK  = 4'd4;
  localparam logic [3:0] S_EXEC = 4'd5;
  localparam logic [3:0] S_WAIT = 4'd6;
  localparam logic [3:0] S_TX   = 4'd7;
  localparam logic [3:0] S_PING = 4'd8;
  localparam logic [3:0] S_ERR  = 4'd9;

  localparam logic [7:0] SYNC      = 8'hA5;
  localparam logic [7:0] CMD_MUL   = 8'h01;
  localparam logic [7:0] CMD_PING  = 8'h02;
  localparam logic [7:0] PING_RESP = 8'h5A;
  localparam logic [7:0] NACK      = 8'hEE;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_TIMEOUT  = 2'b01,
    ERR_CHECKSUM = 2'b10,
    ERR_OPCODE   = 2'b11
  } err_code_t;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Loadable down-counter; raises expire for one cycle when it runs out.
// A reload in the same cycle suppresses the expiry.
module uart_cmd_timeout #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reload,
  input  logic [CNT_W-1:0] load_value,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  always_comb begin
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (reload) begin
      cnt_d = load_value;
    end else if (cnt_q != '0) begin
      cnt_d    = cnt_q - CNT_W'(1);
      expire_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire = expire_q;

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Parses framed multiply/ping requests from the UART byte stream, drives the
// multiplier core and streams a framed response (or NACK) to the TX sink.
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter int          OPERAND_W      = 16,
  parameter logic [7:0]  SYNC_BYTE      = SYNC,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic                   cmd_clock,
  input  logic                   cmd_reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [OPERAND_W-1:0]   op_a,
  output logic [OPERAND_W-1:0]   op_b,
  output logic                   mul_start,
  input  logic                   mul_done,
  input  logic [2*OPERAND_W-1:0] mul_result,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [1:0]             err_code
);

  localparam int N         = OPERAND_W / 8;
  localparam int RES_W     = 2 * OPERAND_W;
  localparam int RES_BYTES = 2 * N;
  localparam int CNT_W     = $clog2(2 * N + 2);

  localparam logic [CNT_W-1:0] LAST_OPND = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_TX   = CNT_W'(2 * N + 1);

  logic [3:0]           state_q, state_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           chk_q, chk_d;
  logic [OPERAND_W-1:0] stage_a_q, stage_a_d;
  logic [OPERAND_W-1:0] stage_b_q, stage_b_d;
  logic [OPERAND_W-1:0] op_a_q, op_a_d;
  logic [OPERAND_W-1:0] op_b_q, op_b_d;
  logic                 mul_start_q, mul_start_d;
  logic [RES_W-1:0]     result_q, result_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  err_code_t            err_q, err_d;

  logic                 rx_edge;
  logic                 tx_fire;
  logic                 tmo_reload;
  logic                 tmo_expire;
  logic                 resp_start;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [7:0]           res_chk;
  logic [RES_W-1:0]     res_shift;

  assign rx_edge = rx_valid & ~rx_valid_q;
  assign tx_fire = tx_valid_q & tx_ready;
  assign cnt_nxt = cnt_q + CNT_W'(1);

  uart_cmd_timeout #(
    .CNT_W (24)
  ) u_timeout (
    .clk        (cmd_clock),
    .rst        (cmd_reset),
    .reload     (tmo_reload),
    .load_value (TIMEOUT_CYCLES),
    .expire     (tmo_expire)
  );

  // Response checksum and the result byte that follows the one on the wire.
  always_comb begin
    res_chk = '0;
    for (int i = 0; i < RES_BYTES; i++) begin
      res_chk = res_chk ^ result_q[i*8 +: 8];
    end
    res_shift = result_q >> (8 * (RES_BYTES - int'(cnt_nxt)));
  end

  always_comb begin
    state_d     = state_q;
    rx_valid_d  = rx_valid;
    cnt_d       = cnt_q;
    chk_d       = chk_q;
    stage_a_d   = stage_a_q;
    stage_b_d   = stage_b_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    mul_start_d = 1'b0;
    result_d    = result_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    err_d       = err_q;
    tmo_reload  = 1'b0;
    resp_start  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_edge && rx_data == SYNC_BYTE) begin
          state_d    = S_CMD;
          tmo_reload = 1'b1;
        end
      end

      S_CMD: begin
        if (rx_edge) begin
          tmo_reload = 1'b1;
          chk_d      = rx_data;
          cnt_d      = '0;
          if (rx_data == CMD_MUL) begin
            state_d = S_OPA;
          end else if (rx_data == CMD_PING) begin
            state_d    = S_PING;
            resp_start = 1'b1;
          end else begin
            state_d    = S_ERR;
            err_d      = ERR_OPCODE;
            resp_start = 1'b1;
          end
        end else if (tmo_expire) begin
          state_d    = S_ERR;
          err_d      = ERR_TIMEOUT;
          resp_start = 1'b1;
        end
      end

      S_OPA: begin
        if (rx_edge) begin
          tmo_reload = 1'b1;
          chk_d      = chk_q ^ rx_data;
          stage_a_d  = (stage_a_q << 8) | OPERAND_W'(rx_data);
          if (cnt_q == LAST_OPND) begin
            cnt_d   = '0;
            state_d = S_OPB;
          end else begin
            cnt_d = cnt_nxt;
          end
        end else if (tmo_expire) begin
          state_d    = S_ERR;
          err_d      = ERR_TIMEOUT;
          resp_start = 1'b1;
        end
      end

      S_OPB: begin
        if (rx_edge) begin
          tmo_reload = 1'b1;
          chk_d      = chk_q ^ rx_data;
          stage_b_d  = (stage_b_q << 8) | OPERAND_W'(rx_data);
          if (cnt_q == LAST_OPND) begin
            cnt_d   = '0;
            state_d = S_CHK;
          end else begin
            cnt_d = cnt_nxt;
          end
        end else if (tmo_expire) begin
          state_d    = S_ERR;
          err_d      = ERR_TIMEOUT;
          resp_start = 1'b1;
        end
      end

      S_CHK: begin
        if (rx_edge) begin
          tmo_reload = 1'b1;
          if (rx_data == chk_q) begin
            state_d = S_EXEC;
          end else begin
            state_d    = S_ERR;
            err_d      = ERR_CHECKSUM;
            resp_start = 1'b1;
          end
        end else if (tmo_expire) begin
          state_d    = S_ERR;
          err_d      = ERR_TIMEOUT;
          resp_start = 1'b1;
        end
      end

      S_EXEC: begin
        op_a_d      = stage_a_q;
        op_b_d      = stage_b_q;
        mul_start_d = 1'b1;
        tmo_reload  = 1'b1;
        state_d     = S_WAIT;
      end

      S_WAIT: begin
        if (mul_done) begin
          result_d   = mul_result;
          err_d      = ERR_NONE;
          state_d    = S_TX;
          resp_start = 1'b1;
        end else if (tmo_expire) begin
          state_d    = S_ERR;
          err_d      = ERR_TIMEOUT;
          resp_start = 1'b1;
        end
      end

      // cnt_q indexes the byte currently presented; advance only on acceptance.
      S_TX: begin
        if (tx_fire) begin
          if (cnt_q == LAST_TX) begin
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
            state_d    = S_IDLE;
          end else begin
            cnt_d     = cnt_nxt;
            tx_data_d = (cnt_nxt == LAST_TX) ? res_chk : res_shift[7:0];
          end
        end
      end

      S_PING: begin
        if (tx_fire) begin
          if (cnt_q == '0) begin
            cnt_d     = cnt_nxt;
            tx_data_d = PING_RESP;
          end else begin
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
            state_d    = S_IDLE;
          end
        end
      end

      S_ERR: begin
        if (tx_fire) begin
          if (cnt_q == '0) begin
            cnt_d     = cnt_nxt;
            tx_data_d = NACK;
          end else if (cnt_q == CNT_W'(1)) begin
            cnt_d     = cnt_nxt;
            tx_data_d = {6'b0, err_q};
          end else begin
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
            state_d    = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (resp_start) begin
      tx_valid_d = 1'b1;
      tx_data_d  = SYNC_BYTE;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge cmd_clock or posedge cmd_reset) begin
    if (cmd_reset) begin
      state_q     <= S_IDLE;
      rx_valid_q  <= 1'b0;
      cnt_q       <= '0;
      chk_q       <= '0;
      stage_a_q   <= '0;
      stage_b_q   <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      mul_start_q <= 1'b0;
      result_q    <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      rx_valid_q  <= rx_valid_d;
      cnt_q       <= cnt_d;
      chk_q       <= chk_d;
      stage_a_q   <= stage_a_d;
      stage_b_q   <= stage_b_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      mul_start_q <= mul_start_d;
      result_q    <= result_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      err_q       <= err_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign mul_start = mul_start_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign err_code  = err_q;

endmodule
